// File: rtl/usrt_rxfifo.sv
// Receive data buffer for the USRT datapath: DEPTH-entry first-word-fall-through FIFO
// with occupancy reporting and a sticky overrun flag for words dropped while full.
module usrt_rxfifo #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 4,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld,
    input  logic [DATA_W-1:0] d,
    input  logic              rd,
    input  logic              clr_ovr,
    output logic [DATA_W-1:0] q,
    output logic              valid,
    output logic              full,
    output logic [AW:0]       count,
    output logic              ovr
);

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]     wp_q, wp_d;
    logic [AW-1:0]     rp_q, rp_d;
    logic [AW:0]       count_q, count_d;
    logic              ovr_q, ovr_d;
    logic              wr_en_s;
    logic              rd_en_s;
    logic              overrun_s;

    assign valid = (count_q != {(AW+1){1'b0}});
    assign full  = (count_q == CNT_FULL);
    assign count = count_q;
    assign ovr   = ovr_q;
    assign q     = valid ? mem_q[rp_q] : {DATA_W{1'b0}};

    // Next-state computation for storage, pointers, occupancy and overrun flag.
    always_comb begin
        // A pop frees a slot this same edge, so a full FIFO still accepts ld with rd.
        wr_en_s   = ld && (!full || rd);
        rd_en_s   = rd && valid;
        overrun_s = ld && full && !rd;

        mem_d = mem_q;
        wp_d  = wp_q;
        rp_d  = rp_q;

        if (wr_en_s) begin
            mem_d[wp_q] = d;
            wp_d        = wp_q + PTR_ONE;
        end else begin
            wp_d = wp_q;
        end

        if (rd_en_s) begin
            rp_d = rp_q + PTR_ONE;
        end else begin
            rp_d = rp_q;
        end

        case ({wr_en_s, rd_en_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // Set wins over clear so a drop in the clearing cycle is never lost.
        if (overrun_s) begin
            ovr_d = 1'b1;
        end else if (clr_ovr) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    // State registers with synchronous reset clearing all storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
            wp_q    <= {AW{1'b0}};
            rp_q    <= {AW{1'b0}};
            count_q <= {(AW+1){1'b0}};
            ovr_q   <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            ovr_q   <= ovr_d;
        end
    end

endmodule

// File: doc/usrt_rxfifo.md
# usrt_rxfifo

Parametrised receive data buffer for the USRT datapath. It replaces the single-entry load register with a DEPTH-entry first-word-fall-through FIFO. Each `ld` pulse from the receive shifter pushes one DATA_W-bit word. The consumer pops words with `rd`. The block reports occupancy and keeps a sticky overrun flag for words dropped while full.

## Interface
- DATA_W, 8, word width in bits (≥1)
- DEPTH, 4, number of entries; power of two, ≥2; AW = log2(DEPTH) is derived internally
- clk  in  1  clock, all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- ld  in  1  push request; `d` is sampled on the same edge
- d  in  DATA_W  write data
- rd  in  1  pop request; acts only when `valid`=1
- clr_ovr  in  1  clears the sticky overrun flag
- q  out  DATA_W  head-of-FIFO word; forced to 0 when `valid`=0
- valid  out  1  FIFO non-empty (count≠0)
- full  out  1  count==DEPTH
- count  out  AW+1  current occupancy, 0..DEPTH
- ovr  out  1  sticky overrun flag

## Operation
- Storage: DEPTH×DATA_W array, write pointer `wp` and read pointer `rp`, each AW bits, both wrap modulo DEPTH. Occupancy is held in `count`; `valid` and `full` decode from `count`.
- Push accepted (`wr_en`) when ld && (!full || rd). In that case mem[wp] <= d and wp <= wp+1.
- Pop accepted (`rd_en`) when rd && valid. In that case rp <= rp+1.
- Count update: +1 if wr_en only; −1 if rd_en only; unchanged if both or neither.
- Full and simultaneous ld+rd: both are accepted, count stays DEPTH, and there is no overrun.
- Empty and simultaneous ld+rd: the push is accepted and the pop is ignored. Count becomes 1.
- rd while empty: no effect. No underflow flag.
- Overrun: ld && full && !rd. The word is dropped, storage and pointers are unchanged, and ovr <= 1.
- clr_ovr: ovr <= 0, unless an overrun occurs in the same cycle. Set has priority over clear.
- q is combinational: mem[rp] when valid, else 0. There is no read latency beyond the push edge.
- Reset (rst=1 at an edge) has priority over all inputs. It sets wp=rp=0, count=0, ovr=0 and clears all storage to 0. If reset hits mid-operation, buffered words are discarded.

## Timing
- Reset values: q=0, valid=0, full=0, count=0, ovr=0.
- Push latency: a word loaded at edge N appears on q (when it is the head) with valid=1 immediately after edge N.
- Pop: after the edge where rd_en=1, q shows the next entry, or 0 if the FIFO is now empty.
- count, full, valid and ovr are registered state, or pure decodes of it. They all update on the same edge as the triggering push or pop.
- ld and rd are level-sampled every cycle. Holding ld high pushes one word per cycle.
- Pointer wrap-around is seamless. Order is preserved across the DEPTH→0 wrap.

## Test plan
- Reset then idle: assert rst for 2 cycles, release → q=0, valid=0, full=0, count=0, ovr=0; rd pulses have no effect.
- Fill (DATA_W=8, DEPTH=4): push 0x11,0x22,0x33,0x44 on consecutive cycles → count steps 1..4, full=1 after 4th edge, q=0x11 throughout.
- Overrun: with FIFO full, ld with d=0x55 and rd=0 → ovr=1, count=4. Then drain 4 pops → q sequence 0x11,0x22,0x33,0x44, valid=0, q=0; 0x55 is never seen.
- Full pass-through: with FIFO full of 0xA0..0xA3, ld (d=0xA4) and rd in the same cycle → count stays 4, ovr stays 0, q=0xA1. Later drain yields A1,A2,A3,A4.
- Wrap and empty edge: push and pop 10 words (0x01..0x0A) with occupancy ≤2 so pointers wrap twice → output order matches. Empty FIFO with ld(0x7E)+rd → count=1, q=0x7E.
- Flag and reset priority: overrun and clr_ovr in the same cycle → ovr=1; clr_ovr alone → ovr=0. Then push 2 words and assert rst with ld=1 in the same cycle → count=0, valid=0, q=0.
